// File: rtl/trng_pkg.sv
// Shared constants and encodings for the TRNG harvester slice.
package trng_pkg;

    localparam int WORD_W         = 16;
    localparam int RCT_CUTOFF_DEF = 32;
    localparam int APT_WINDOW_DEF = 512;
    localparam int APT_CUTOFF_DEF = 410;

    // Top-level harvester mode.
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_FAIL = 1'b1
    } trng_state_e;

    // Von Neumann debiaser pair position.
    typedef enum logic {
        PH_FIRST  = 1'b0,
        PH_SECOND = 1'b1
    } trng_phase_e;

endpackage

// File: rtl/trng_harvester_if.sv
// Output word handshake of the harvester.
// Valid/ready: the master raises out_valid with out_data and holds both
// unchanged until an edge where out_valid and out_ready are both high; that
// edge is the transfer. out_ready may toggle freely and never depends on
// out_valid being low.
interface trng_harvester_if;
    import trng_pkg::*;

    logic [WORD_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);

endinterface

// File: rtl/trng_health.sv
// Continuous health tests on the folded bit stream: repetition count and
// adaptive proportion. fail pulses on the sample edge that trips either test.
module trng_health #(
    parameter int RCT_CUTOFF = trng_pkg::RCT_CUTOFF_DEF,
    parameter int APT_WINDOW = trng_pkg::APT_WINDOW_DEF,
    parameter int APT_CUTOFF = trng_pkg::APT_CUTOFF_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sample_valid,
    input  logic folded_bit,
    input  logic clear,
    output logic fail
);
    localparam int RCT_W = $clog2(RCT_CUTOFF + 1);
    localparam int APT_W = $clog2(APT_WINDOW + 1);
    localparam int POS_W = (APT_WINDOW > 1) ? $clog2(APT_WINDOW) : 1;

    // rct_q == 0 means no sample seen yet since reset/clear.
    logic [RCT_W-1:0] rct_q, rct_d;
    logic             prev_q, prev_d;
    logic [APT_W-1:0] apt_q, apt_d;
    logic             ref_q, ref_d;
    logic [POS_W-1:0] pos_q, pos_d;

    // Next-state of both test counters and the trip decision.
    always_comb begin
        rct_d  = rct_q;
        prev_d = prev_q;
        apt_d  = apt_q;
        ref_d  = ref_q;
        pos_d  = pos_q;
        fail   = 1'b0;
        if (clear) begin
            rct_d  = '0;
            prev_d = 1'b0;
            apt_d  = '0;
            ref_d  = 1'b0;
            pos_d  = '0;
        end else if (sample_valid) begin
            prev_d = folded_bit;
            if (rct_q != '0 && folded_bit == prev_q) rct_d = rct_q + RCT_W'(1);
            else                                     rct_d = RCT_W'(1);
            if (pos_q == '0) begin
                ref_d = folded_bit;
                apt_d = APT_W'(1);
            end else if (folded_bit == ref_q) begin
                apt_d = apt_q + APT_W'(1);
            end
            pos_d = (pos_q == POS_W'(APT_WINDOW - 1)) ? '0 : pos_q + POS_W'(1);
            fail  = (rct_d == RCT_W'(RCT_CUTOFF)) || (apt_d == APT_W'(APT_CUTOFF));
        end
    end

    // Test counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rct_q  <= '0;
            prev_q <= 1'b0;
            apt_q  <= '0;
            ref_q  <= 1'b0;
            pos_q  <= '0;
        end else begin
            rct_q  <= rct_d;
            prev_q <= prev_d;
            apt_q  <= apt_d;
            ref_q  <= ref_d;
            pos_q  <= pos_d;
        end
    end

endmodule

// File: rtl/trng_harvester.sv
// Ring-oscillator harvester: fold, von Neumann debias, pack into 16-bit
// words behind a valid/ready output, guarded by health tests.
module trng_harvester
    import trng_pkg::*;
#(
    parameter int RCT_CUTOFF = RCT_CUTOFF_DEF,
    parameter int APT_WINDOW = APT_WINDOW_DEF,
    parameter int APT_CUTOFF = APT_CUTOFF_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [WORD_W-1:0]   raw_in,
    input  logic                en,
    output logic                health_fail,
    input  logic                clr_fail,
    trng_harvester_if.master    out_if,
    output trng_state_e         state_o
);
    localparam int CNT_W = $clog2(WORD_W + 1);

    trng_state_e       state_q, state_d;
    trng_phase_e       phase_q, phase_d;
    logic              b0_q, b0_d;
    logic [WORD_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WORD_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;

    logic sample, fold, xfer, trip, clr, emit;

    assign sample = en && (state_q == ST_RUN);
    assign fold   = ^raw_in;
    assign xfer   = out_valid_q && out_if.out_ready;
    assign clr    = clr_fail && (state_q == ST_FAIL);

    trng_health #(
        .RCT_CUTOFF (RCT_CUTOFF),
        .APT_WINDOW (APT_WINDOW),
        .APT_CUTOFF (APT_CUTOFF)
    ) u_health (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_valid (sample),
        .folded_bit   (fold),
        .clear        (clr),
        .fail         (trip)
    );

    // RUN/FAIL next state; clr_fail only acts in FAIL.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:  if (trip)     state_d = ST_FAIL;
            ST_FAIL: if (clr_fail) state_d = ST_RUN;
            default:               state_d = ST_RUN;
        endcase
    end

    // Debiaser, accumulator and output register next state.
    always_comb begin
        phase_d     = phase_q;
        b0_d        = b0_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        emit        = 1'b0;
        if (xfer) out_valid_d = 1'b0;
        if (sample) begin
            if (phase_q == PH_FIRST) begin
                b0_d    = fold;
                phase_d = PH_SECOND;
            end else begin
                phase_d = PH_FIRST;
                emit    = (b0_q != fold);
            end
        end
        if (cnt_q == CNT_W'(WORD_W)) begin
            // Full accumulator waits for the output register; new bits drop.
            if (xfer) begin
                out_data_d  = acc_q;
                out_valid_d = 1'b1;
                cnt_d       = '0;
            end
        end else if (emit) begin
            acc_d = {acc_q[WORD_W-2:0], b0_q};
            if (cnt_q == CNT_W'(WORD_W - 1)) begin
                if (!out_valid_q || xfer) begin
                    out_data_d  = acc_d;
                    out_valid_d = 1'b1;
                    cnt_d       = '0;
                end else begin
                    cnt_d = CNT_W'(WORD_W);
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        // A trip, and the whole FAIL period, flushes every word in flight.
        if (state_q == ST_FAIL || trip) begin
            phase_d     = PH_FIRST;
            b0_d        = 1'b0;
            acc_d       = '0;
            cnt_d       = '0;
            out_data_d  = '0;
            out_valid_d = 1'b0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            phase_q     <= PH_FIRST;
            b0_q        <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            b0_q        <= b0_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_if.out_data  = out_data_q;
    assign out_if.out_valid = out_valid_q;
    assign health_fail      = (state_q == ST_FAIL);
    assign state_o          = state_q;

endmodule

// File: tb/tb_trng_harvester.sv
// Self-checking bench for trng_harvester: directed scenarios plus a
// randomized run against a behavioural stream model.
module tb_trng_harvester;
  import trng_pkg::*;

  logic              clk;
  logic              rst_n;
  logic [15:0]       raw_in;
  logic              en;
  logic              clr_fail;
  logic              health_fail;
  trng_state_e       state_o;
  trng_harvester_if  out_if();

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] exp_q[$];

  trng_harvester #(
    .RCT_CUTOFF (RCT_CUTOFF_DEF),
    .APT_WINDOW (APT_WINDOW_DEF),
    .APT_CUTOFF (APT_CUTOFF_DEF)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .raw_in      (raw_in),
    .en          (en),
    .health_fail (health_fail),
    .clr_fail    (clr_fail),
    .out_if      (out_if),
    .state_o     (state_o)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Stream view: folded samples -> debiased bit pairs -> 16-bit words,
  // with one output slot and one parked full word.
  bit          m_fail, m_ov, m_have_b0, m_b0, m_held, m_last, m_ref;
  logic [15:0] m_od, m_word, m_held_word;
  int          m_bits, m_run, m_pos, m_match;

  task automatic model_clear_tests();
    m_run = 0; m_pos = 0; m_match = 0; m_last = 0; m_ref = 0;
  endtask

  task automatic model_reset();
    m_fail = 0; m_ov = 0; m_od = '0; m_have_b0 = 0; m_b0 = 0;
    m_held = 0; m_held_word = '0; m_word = '0; m_bits = 0;
    model_clear_tests();
  endtask

  task automatic model_edge();
    bit xfer, was_held, f, trip, emit, b;
    if (!rst_n) begin model_reset(); return; end
    if (m_fail) begin
      if (clr_fail) begin m_fail = 0; model_clear_tests(); end
      return;
    end
    xfer = m_ov && out_if.out_ready;
    was_held = m_held;
    if (xfer) begin
      if (m_held) begin m_od = m_held_word; m_held = 0; end
      else m_ov = 0;
    end
    if (!en) return;
    f = ^raw_in; trip = 0; emit = 0; b = 0;
    if (m_run != 0 && f == m_last) m_run++; else m_run = 1;
    m_last = f;
    if (m_run == RCT_CUTOFF_DEF) trip = 1;
    if (m_pos == 0) begin m_ref = f; m_match = 1; end
    else if (f == m_ref) begin m_match++; if (m_match == APT_CUTOFF_DEF) trip = 1; end
    m_pos = (m_pos + 1) % APT_WINDOW_DEF;
    if (!m_have_b0) begin m_b0 = f; m_have_b0 = 1; end
    else begin m_have_b0 = 0; emit = (m_b0 != f); b = m_b0; end
    if (trip) begin
      m_fail = 1; m_ov = 0; m_od = '0; m_bits = 0; m_held = 0;
      m_have_b0 = 0; m_word = '0;
      return;
    end
    if (emit && !was_held) begin
      m_word = {m_word[14:0], b};
      m_bits++;
      if (m_bits == 16) begin
        m_bits = 0;
        if (!m_ov) begin m_od = m_word; m_ov = 1; end
        else begin m_held = 1; m_held_word = m_word; end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  function automatic logic [15:0] gen_raw(input bit f);
    logic [15:0] r;
    r = 16'($urandom);
    if ((^r) != f) r[0] = ~r[0];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; clr_fail = 1'b0; out_if.out_ready = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    raw_in = 16'hA5A5;
    do_reset();
    n_checks++;
    if (out_if.out_data !== 16'h0000) begin n_fail++;
      $display("FAIL reset_data: got %h expected 0000", out_if.out_data); end
    n_checks++;
    if (out_if.out_valid !== 1'b0) begin n_fail++;
      $display("FAIL reset_valid: got %b expected 0", out_if.out_valid); end
    n_checks++;
    if (health_fail !== 1'b0) begin n_fail++;
      $display("FAIL reset_health: got %b expected 0", health_fail); end
    n_checks++;
    if (state_o !== ST_RUN) begin n_fail++;
      $display("FAIL reset_state: got %0d expected %0d", state_o, ST_RUN); end
  endtask

  task automatic test_pairs(input bit first, input logic [15:0] exp_word);
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 32; i++) begin
      raw_in = gen_raw((i % 2 == 0) ? first : ~first);
      tick();
      if (i == 30) begin
        n_checks++;
        if (out_if.out_valid !== 1'b0) begin n_fail++;
          $display("FAIL pairs_early_valid: got %b expected 0 at edge 31", out_if.out_valid); end
      end
    end
    en = 1'b0;
    n_checks++;
    if (out_if.out_valid !== 1'b1) begin n_fail++;
      $display("FAIL pairs_valid: got %b expected 1", out_if.out_valid); end
    n_checks++;
    if (out_if.out_data !== exp_word) begin n_fail++;
      $display("FAIL pairs_data: got %h expected %h", out_if.out_data, exp_word); end
    n_checks++;
    if (health_fail !== 1'b0) begin n_fail++;
      $display("FAIL pairs_health: got %b expected 0", health_fail); end
  endtask

  task automatic test_rct();
    do_reset();
    out_if.out_ready = 1'b1;
    raw_in = 16'h0000;
    en = 1'b1;
    for (int i = 0; i < 32; i++) begin
      tick();
      if (i == 30) begin
        n_checks++;
        if (health_fail !== 1'b0) begin n_fail++;
          $display("FAIL rct_early: got %b expected 0 at edge 31", health_fail); end
      end
    end
    en = 1'b0;
    n_checks++;
    if (health_fail !== 1'b1) begin n_fail++;
      $display("FAIL rct_trip: got %b expected 1", health_fail); end
    n_checks++;
    if (out_if.out_valid !== 1'b0) begin n_fail++;
      $display("FAIL rct_valid: got %b expected 0", out_if.out_valid); end
  endtask

  // Expects to start in FAIL (follows test_rct).
  task automatic test_clr();
    clr_fail = 1'b1;
    tick();
    clr_fail = 1'b0;
    n_checks++;
    if (health_fail !== 1'b0) begin n_fail++;
      $display("FAIL clr_health: got %b expected 0", health_fail); end
    out_if.out_ready = 1'b0;
    en = 1'b1;
    for (int i = 0; i < 32; i++) begin
      raw_in = gen_raw((i % 2 == 0) ? 1'b1 : 1'b0);
      clr_fail = (i == 10);  // ignored while running
      tick();
      if (i == 30) begin
        n_checks++;
        if (out_if.out_valid !== 1'b0) begin n_fail++;
          $display("FAIL clr_early_valid: got %b expected 0", out_if.out_valid); end
      end
    end
    en = 1'b0; clr_fail = 1'b0;
    n_checks++;
    if (out_if.out_valid !== 1'b1 || out_if.out_data !== 16'hFFFF) begin n_fail++;
      $display("FAIL clr_word: got valid %b data %h expected 1 FFFF",
               out_if.out_valid, out_if.out_data); end
  endtask

  task automatic test_backpressure();
    logic [15:0] w;
    int nb;
    bit b;
    do_reset();
    exp_q.delete();
    w = '0; nb = 0; b = 0;
    en = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (i % 2 == 0) begin
        b = 1'($urandom_range(0, 1));
        raw_in = gen_raw(b);
      end else begin
        raw_in = gen_raw(~b);
        if (nb < 32) begin
          w = {w[14:0], b};
          nb++;
          if (nb % 16 == 0) exp_q.push_back(w);
        end
      end
      tick();
      if (i >= 31) begin
        n_checks++;
        if (out_if.out_valid !== 1'b1 || out_if.out_data !== exp_q[0]) begin n_fail++;
          $display("FAIL bp_hold: got valid %b data %h expected 1 %h at edge %0d",
                   out_if.out_valid, out_if.out_data, exp_q[0], i + 1); end
      end
    end
    en = 1'b0;
    out_if.out_ready = 1'b1;
    void'(exp_q.pop_front());
    tick();
    n_checks++;
    if (out_if.out_valid !== 1'b1 || out_if.out_data !== exp_q[0]) begin n_fail++;
      $display("FAIL bp_second: got valid %b data %h expected 1 %h",
               out_if.out_valid, out_if.out_data, exp_q[0]); end
    tick();
    n_checks++;
    if (out_if.out_valid !== 1'b0) begin n_fail++;
      $display("FAIL bp_drain: got valid %b expected 0", out_if.out_valid); end
    out_if.out_ready = 1'b0;
  endtask

  task automatic test_mid_reset();
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      raw_in = gen_raw((i % 2 == 0) ? 1'b1 : 1'b0);
      tick();
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_checks++;
    if (out_if.out_valid !== 1'b0 || out_if.out_data !== 16'h0000 || health_fail !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_outputs: got valid %b data %h health %b expected 0 0000 0",
               out_if.out_valid, out_if.out_data, health_fail); end
    for (int i = 0; i < 32; i++) begin
      raw_in = gen_raw((i % 2 == 0) ? 1'b0 : 1'b1);
      tick();
      if (i == 30) begin
        n_checks++;
        if (out_if.out_valid !== 1'b0) begin n_fail++;
          $display("FAIL midrst_early: got %b expected 0", out_if.out_valid); end
      end
    end
    en = 1'b0;
    n_checks++;
    if (out_if.out_valid !== 1'b1 || out_if.out_data !== 16'h0000) begin n_fail++;
      $display("FAIL midrst_word: got valid %b data %h expected 1 0000",
               out_if.out_valid, out_if.out_data); end
  endtask

  // 20 zeros then a single one, repeated: zeros reach 410 on sample 430.
  task automatic test_apt();
    do_reset();
    out_if.out_ready = 1'b1;
    en = 1'b1;
    for (int i = 0; i < 430; i++) begin
      raw_in = gen_raw(i % 21 == 20);
      tick();
      if (i == 428) begin
        n_checks++;
        if (health_fail !== 1'b0) begin n_fail++;
          $display("FAIL apt_early: got %b expected 0 at sample 429", health_fail); end
      end
    end
    en = 1'b0;
    n_checks++;
    if (health_fail !== 1'b1) begin n_fail++;
      $display("FAIL apt_trip: got %b expected 1 at sample 430", health_fail); end
  endtask

  task automatic test_random();
    int mode;
    do_reset();
    mode = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 250 == 0) mode = $urandom_range(0, 2);
      case (mode)
        0:       raw_in = 16'($urandom);
        1:       raw_in = gen_raw($urandom_range(0, 31) == 0);
        default: raw_in = gen_raw($urandom_range(0, 15) == 0);
      endcase
      en               = ($urandom_range(0, 7) != 0);
      out_if.out_ready = ($urandom_range(0, 3) != 0);
      clr_fail         = ($urandom_range(0, 39) == 0);
      tick();
      n_checks++;
      if (health_fail !== m_fail) begin n_fail++;
        $display("FAIL rand_health: got %b expected %b at cycle %0d", health_fail, m_fail, i); end
      n_checks++;
      if (out_if.out_valid !== m_ov) begin n_fail++;
        $display("FAIL rand_valid: got %b expected %b at cycle %0d", out_if.out_valid, m_ov, i); end
      if (m_ov) begin
        n_checks++;
        if (out_if.out_data !== m_od) begin n_fail++;
          $display("FAIL rand_data: got %h expected %h at cycle %0d", out_if.out_data, m_od, i); end
      end
    end
    en = 1'b0; clr_fail = 1'b0; out_if.out_ready = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst_n = 1'b0; en = 1'b0; clr_fail = 1'b0; raw_in = '0;
    out_if.out_ready = 1'b0;
    model_reset();
    test_reset();
    test_pairs(1'b0, 16'h0000);
    test_pairs(1'b1, 16'hFFFF);
    test_rct();
    test_clr();
    test_backpressure();
    test_mid_reset();
    test_apt();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/trng_harvester.md
TRNG_HARVESTER -- requirements
Module: trng_harvester

Interface
REQ-001 SHALL have parameter RCT_CUTOFF, default 32, repetition-count fail threshold (consecutive identical folded bits).
REQ-002 SHALL have parameter APT_WINDOW, default 512, adaptive-proportion window length in folded samples.
REQ-003 SHALL have parameter APT_CUTOFF, default 410, adaptive-proportion fail threshold (matches within one window).
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-006 SHALL have port raw_in, input, 16, registered 16-bit sample word from the ring-oscillator generator.
REQ-007 SHALL have port en, input, 1, harvest enable; sampling and tests advance only while high.
REQ-008 SHALL have port out_data, output, 16, conditioned random word.
REQ-009 SHALL have port out_valid, output, 1, out_data holds an unconsumed word.
REQ-010 SHALL have port out_ready, input, 1, consumer accepts the word; a transfer occurs on an edge where out_valid and out_ready are both high.
REQ-011 SHALL have port health_fail, output, 1, sticky health-test failure flag.
REQ-012 SHALL have port clr_fail, input, 1, single-cycle pulse that clears the failure and restarts harvesting.

Function
REQ-013 SHALL fold each enabled sample to one bit f = XOR of all 16 raw_in bits.
REQ-014 SHALL apply a von Neumann debiaser over consecutive folded bits: phase FIRST stores b0; phase SECOND takes b1, emits b0 if b0 != b1, emits nothing if equal, then returns to FIRST.
REQ-015 SHALL shift each emitted bit into the accumulator LSB, shifting left, and track a 0..16 fill count.
REQ-016 SHALL, on the edge of the 16th emitted bit, load the completed word into out_data and set out_valid if the output register is empty or a transfer occurs on that same edge; the accumulator count then returns to 0.
REQ-017 SHALL, when the output register is full and not transferring, hold a full accumulator (count 16) and drop further emitted bits; the held word moves to out_data on the edge of the next transfer.
REQ-018 SHALL keep out_data stable while out_valid is high and out_ready is low.
REQ-019 SHALL, while en is low, freeze debiaser phase, accumulator and test state; output handshake continues.
REQ-020 SHALL implement a repetition count test: counter set to 1 on the first sample, incremented on a folded bit equal to the previous one, reset to 1 otherwise; reaching RCT_CUTOFF sets health_fail.
REQ-021 SHALL implement an adaptive proportion test: the first sample of each window is the reference; count samples equal to it over APT_WINDOW samples (reference included); count reaching APT_CUTOFF sets health_fail; a new window starts after the last sample.
REQ-022 SHALL use a two-state FSM: RUN (harvesting) and FAIL (entered when either test trips).
REQ-023 SHALL, on entering FAIL: hold health_fail high, force out_valid low, discard out_data contents, clear the accumulator, and stop sampling.
REQ-024 SHALL, on clr_fail in FAIL, return to RUN with debiaser phase FIRST, accumulator empty, both test counters reset, and health_fail low on the next cycle.
REQ-025 SHALL give clr_fail priority over a failure detected on the same edge; clr_fail in RUN has no effect.

Reset
REQ-026 SHALL, on rst_n low at a clock edge, set out_data 0x0000, out_valid 0, health_fail 0, FSM RUN, debiaser phase FIRST, accumulator and count 0, RCT and APT counters and window position 0.
REQ-027 SHALL discard any partial or pending word when reset is asserted mid-operation.

Structure
REQ-028 SHALL place the parameter defaults and the RUN/FAIL state encoding in shared package trng_pkg.
REQ-029 SHALL implement RCT and APT in sub-module trng_health (inputs clk, rst_n, sample valid, folded bit, clear; output fail).

Verification
REQ-030 SHALL cover: en high, folded bits 0,1 repeated from reset release -> out_valid rises after edge 32 with out_data 0x0000; health_fail stays 0.
REQ-031 SHALL cover: folded bits 1,0 repeated -> out_data 0xFFFF after edge 32.
REQ-032 SHALL cover: raw_in held 0x0000 -> no word emitted; health_fail rises after edge 32 (RCT), out_valid stays 0.
REQ-033 SHALL cover: out_ready low for 100 cycles with 0,1/1,0 pair stream -> first word held stable, second word held full in accumulator, excess bits dropped; out_ready high -> two consecutive transfers.
REQ-034 SHALL cover: failure then clr_fail pulse -> health_fail low next cycle, fresh word after 32 further enabled edges of valid pairs.
REQ-035 SHALL cover: rst_n low after 10 emitted bits -> all outputs at reset values, next word built from 16 new bits only.
